// File: rtl/mem_ctrl_pkg.sv
// Shared controller types: host operation codes, SPI SRAM command bytes and the
// serial memory controller FSM states, plus the SPI frame builder.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      MEM_NOP   = 2'b00,
      MEM_READ  = 2'b01,
      MEM_WRITE = 2'b10
   } mem_ctrl_op_e;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      SHIFT   = 2'b01,
      DONE    = 2'b10,
      RECOVER = 2'b11
   } mem_state_e;

   localparam logic [7:0] SPI_CMD_READ  = 8'h03;
   localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

   localparam int FRAME_W      = 32;
   localparam int FRAME_ADDR_W = 16;
   localparam int FRAME_DATA_W = 8;

   // Read frames carry a don't-care data byte, sent as zero.
   function automatic logic [FRAME_W-1:0] build_frame(
      input logic                    is_read,
      input logic [FRAME_ADDR_W-1:0] frame_addr,
      input logic [FRAME_DATA_W-1:0] frame_data
   );
      if (is_read) begin
         return {SPI_CMD_READ, frame_addr, 8'h00};
      end
      return {SPI_CMD_WRITE, frame_addr, frame_data};
   endfunction

endpackage

// File: rtl/mem_ctrl_spi_shifter.sv
// 32-bit parallel-load, MSB-first shift register; MISO is captured into a
// holding bit and enters the LSB on the following shift.
module spi_shifter
   import mem_ctrl_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               load,
   input  logic [FRAME_W-1:0] frame_in,
   input  logic               sample_en,
   input  logic               shift_en,
   input  logic               miso,
   output logic               mosi_bit,
   output logic [7:0]         rx_byte
);

   logic [FRAME_W-1:0] sr_q, sr_d;
   logic               sample_q, sample_d;

   always_comb begin
      sr_d     = sr_q;
      sample_d = sample_q;
      if (load) begin
         sr_d = frame_in;
      end else if (shift_en) begin
         sr_d = {sr_q[FRAME_W-2:0], sample_q};
      end
      if (sample_en) begin
         sample_d = miso;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sr_q     <= '0;
         sample_q <= 1'b0;
      end else begin
         sr_q     <= sr_d;
         sample_q <= sample_d;
      end
   end

   assign mosi_bit = sr_q[FRAME_W-1];
   // Value the low byte takes after the next shift: the last eight MISO samples.
   assign rx_byte  = {sr_q[6:0], sample_q};

endmodule

// File: rtl/mem_ctrl.sv
// SPI SRAM controller: accepts one host read/write, runs a 32-bit mode-0 frame
// at clock/2, pulses mem_op_done, then spends one recovery cycle before idling.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int DATA_BUS_WIDTH = 8,
   parameter int ADDR_WIDTH     = 16
)(
   input  logic                      clock,
   input  logic                      reset,
   input  mem_ctrl_op_e              mem_ctrl_op,
   input  logic [ADDR_WIDTH-1:0]     addr,
   input  logic [DATA_BUS_WIDTH-1:0] data_in,
   output logic [DATA_BUS_WIDTH-1:0] data_out,
   output logic                      mem_op_done,
   output logic                      spi_cs_n,
   output logic                      spi_sclk,
   output logic                      spi_mosi,
   input  logic                      spi_miso
);

   mem_state_e                state_q, state_d;
   logic                      phase_q, phase_d;
   logic [4:0]                bit_cnt_q, bit_cnt_d;
   logic                      is_read_q, is_read_d;
   logic [DATA_BUS_WIDTH-1:0] data_out_q, data_out_d;

   logic               load;
   logic               sample_en;
   logic               shift_en;
   logic [FRAME_W-1:0] frame;
   logic               mosi_bit;
   logic [7:0]         rx_byte;

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      bit_cnt_d  = bit_cnt_q;
      is_read_d  = is_read_q;
      data_out_d = data_out_q;
      load       = 1'b0;
      sample_en  = 1'b0;
      shift_en   = 1'b0;
      frame      = build_frame(mem_ctrl_op == MEM_READ,
                               FRAME_ADDR_W'(addr),
                               FRAME_DATA_W'(data_in));

      unique case (state_q)
         IDLE: begin
            if (mem_ctrl_op == MEM_READ || mem_ctrl_op == MEM_WRITE) begin
               load      = 1'b1;
               is_read_d = (mem_ctrl_op == MEM_READ);
               phase_d   = 1'b0;
               bit_cnt_d = 5'd0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            // phase 0 = sclk low half (MISO sampled at its end), phase 1 = sclk high half
            if (!phase_q) begin
               sample_en = 1'b1;
               phase_d   = 1'b1;
            end else begin
               shift_en  = 1'b1;
               phase_d   = 1'b0;
               bit_cnt_d = bit_cnt_q + 5'd1;
               if (bit_cnt_q == 5'd31) begin
                  state_d = DONE;
                  if (is_read_q) begin
                     data_out_d = DATA_BUS_WIDTH'(rx_byte);
                  end
               end
            end
         end
         DONE: begin
            state_d = RECOVER;
         end
         RECOVER: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         phase_q    <= 1'b0;
         bit_cnt_q  <= 5'd0;
         is_read_q  <= 1'b0;
         data_out_q <= '0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         bit_cnt_q  <= bit_cnt_d;
         is_read_q  <= is_read_d;
         data_out_q <= data_out_d;
      end
   end

   spi_shifter u_shifter (
      .clock     (clock),
      .reset     (reset),
      .load      (load),
      .frame_in  (frame),
      .sample_en (sample_en),
      .shift_en  (shift_en),
      .miso      (spi_miso),
      .mosi_bit  (mosi_bit),
      .rx_byte   (rx_byte)
   );

   // Outputs decode straight from state so the async reset idles the bus at once.
   assign spi_cs_n    = (state_q != SHIFT);
   assign spi_sclk    = (state_q == SHIFT) && phase_q;
   assign spi_mosi    = (state_q == SHIFT) && mosi_bit;
   assign mem_op_done = (state_q == DONE);
   assign data_out    = data_out_q;

endmodule
